// File: rtl/imem_loader_pkg.sv
// Shared CPU-side definitions for the instruction memory loader:
// loader FSM states, the default frame marker and the frame length check.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      SYNC,
      LEN,
      DATA,
      CSUM,
      DONE,
      ERROR
   } loader_state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // A frame carries len+1 data bytes; it must fit in a 2^aw deep memory.
   function automatic logic len_fits(input logic [7:0] len, input int aw);
      return (int'(len) + 1) <= (1 << aw);
   endfunction

endpackage

// File: rtl/imem_write_ifc.sv
// Write port of the instruction memory; the loader drives it, the
// memory consumes it alongside the fetch-stage read path.
interface imem_write_ifc #(
   parameter int ADDR_WIDTH = 8
);
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [7:0]            wdata;

   modport writer (output we, addr, wdata);
   modport reader (input  we, addr, wdata);
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses SYNC/LEN/DATA/CSUM frames, writes the
// instruction memory and releases the core only after a checksum-valid image.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         ADDR_WIDTH = 8,
   parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   input  logic                  restart,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [7:0]            imem_wdata,
   output logic                  core_run,
   output logic                  done,
   output logic                  error
);

   loader_state_t         state;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [ADDR_WIDTH-1:0] last_addr;
   logic [7:0]            sum;
   logic [7:0]            csum_total;
   logic                  accept;

   imem_write_ifc #(.ADDR_WIDTH(ADDR_WIDTH)) wr_if ();

   // Decoded from the state register only, so rx_valid never loops back.
   assign rx_ready   = (state == SYNC) || (state == LEN) ||
                       (state == DATA) || (state == CSUM);
   assign accept     = rx_valid && rx_ready;
   assign csum_total = sum + rx_data;

   assign imem_we    = wr_if.we;
   assign imem_addr  = wr_if.addr;
   assign imem_wdata = wr_if.wdata;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= SYNC;
         addr_cnt    <= '0;
         last_addr   <= '0;
         sum         <= '0;
         wr_if.we    <= 1'b0;
         wr_if.addr  <= '0;
         wr_if.wdata <= '0;
         core_run    <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         // NOTE: non-blocking default makes the write strobe a one-cycle pulse;
         // the later assignment in the DATA branch overrides it for that edge.
         wr_if.we <= 1'b0;
         if (restart) begin
            state     <= SYNC;
            addr_cnt  <= '0;
            last_addr <= '0;
            sum       <= '0;
            core_run  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
         end else if (accept) begin
            case (state)
               SYNC: begin
                  if (rx_data == SYNC_BYTE) state <= LEN;
               end
               LEN: begin
                  sum       <= '0;
                  addr_cnt  <= '0;
                  last_addr <= rx_data[ADDR_WIDTH-1:0];
                  if (len_fits(rx_data, ADDR_WIDTH)) begin
                     state <= DATA;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
               DATA: begin
                  wr_if.we    <= 1'b1;
                  wr_if.addr  <= addr_cnt;
                  wr_if.wdata <= rx_data;
                  sum         <= csum_total;
                  // The counter stops on the last byte, so it never wraps.
                  if (addr_cnt == last_addr) state <= CSUM;
                  else addr_cnt <= addr_cnt + 1'b1;
               end
               CSUM: begin
                  if (csum_total == 8'h00) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     core_run <= 1'b1;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame-level model predicts every
// memory write and the final status; directed frames exercise each path.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int OUT_RUN  = 0;
   localparam int OUT_DONE = 1;
   localparam int OUT_ERR  = 2;

   typedef logic [7:0] bytes_t[$];
   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       restart = 1'b0;
   logic       rx_ready, imem_we, core_run, done, error;
   logic [7:0] imem_addr, imem_wdata;

   logic       s_rx_valid = 1'b0;
   logic [7:0] s_rx_data = 8'h00;
   logic       s_restart = 1'b0;
   logic       s_rx_ready, s_we, s_core_run, s_done, s_error;
   logic [3:0] s_addr;
   logic [7:0] s_wdata;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int n_writes = 0;
   int s_writes = 0;
   int n0;
   int outcome;
   wr_t exp_wr[$];
   wr_t e_cmp;
   int wr_cyc[$];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(8)) dut (
      .clk(clk), .n_rst(n_rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .restart(restart), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_run(core_run),
      .done(done), .error(error)
   );

   imem_loader #(.ADDR_WIDTH(4)) dut_small (
      .clk(clk), .n_rst(n_rst), .rx_valid(s_rx_valid), .rx_data(s_rx_data),
      .rx_ready(s_rx_ready), .restart(s_restart), .imem_we(s_we),
      .imem_addr(s_addr), .imem_wdata(s_wdata), .core_run(s_core_run),
      .done(s_done), .error(s_error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Frame-level model: find the marker, read L, take L+1 data bytes, then C.
   function automatic int model(input bytes_t s, input int aw, input bit push);
      int i = 0;
      int len;
      logic [7:0] total = 8'h00;
      while (i < s.size() && s[i] != 8'hA5) i++;
      if (i >= s.size() - 1) return OUT_RUN;
      len = int'(s[i+1]);
      i += 2;
      if (len + 1 > 2 ** aw) return OUT_ERR;
      for (int k = 0; k <= len; k++) begin
         if (i >= s.size()) return OUT_RUN;
         if (push) exp_wr.push_back('{addr: 8'(k), data: s[i]});
         total += s[i];
         i++;
      end
      if (i >= s.size()) return OUT_RUN;
      total += s[i];
      return (total == 8'h00) ? OUT_DONE : OUT_ERR;
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (n_rst) begin
         if (imem_we) begin
            n_writes++;
            wr_cyc.push_back(cyc);
            if (exp_wr.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               e_cmp = exp_wr.pop_front();
               check("wr_addr", imem_addr, e_cmp.addr);
               check("wr_data", imem_wdata, e_cmp.data);
            end
         end
         check("core_run_eq_done", core_run, done);
         check("rx_ready_vs_status", rx_ready, !(done || error));
      end
   end

   always @(negedge clk) if (n_rst && s_we) s_writes++;

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_stream(input bytes_t s, input int max_gap);
      for (int i = 0; i < s.size(); i++) begin
         send(s[i]);
         if (max_gap > 0 && i < s.size() - 1)
            repeat ($urandom_range(1, max_gap)) @(negedge clk);
      end
   endtask

   task automatic s_send(input logic [7:0] b);
      s_rx_valid = 1'b1;
      s_rx_data  = b;
      @(posedge clk);
      @(negedge clk);
      s_rx_valid = 1'b0;
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("restart_done", done, 0);
      check("restart_error", error, 0);
      check("restart_core_run", core_run, 0);
      check("restart_rx_ready", rx_ready, 1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rx_ready"}, rx_ready, 1);
      check({tag, "_imem_we"}, imem_we, 0);
      check({tag, "_imem_addr"}, imem_addr, 0);
      check({tag, "_imem_wdata"}, imem_wdata, 0);
      check({tag, "_core_run"}, core_run, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
   endtask

   task automatic expect_done(input string tag, input int writes);
      check({tag, "_done"}, done, 1);
      check({tag, "_core_run"}, core_run, 1);
      check({tag, "_error"}, error, 0);
      check({tag, "_rx_ready"}, rx_ready, 0);
      check({tag, "_pending_writes"}, exp_wr.size(), 0);
      check({tag, "_write_count"}, n_writes - n0, writes);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
      $fatal(1, "time limit");
   end

   initial begin
      bytes_t basic, bad, junk, prefix;
      basic  = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h9A};
      bad    = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h9B};
      junk   = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h9A};
      prefix = '{8'hA5, 8'h02, 8'h11, 8'h22};

      // Reset state
      @(negedge clk);
      check_reset_values("reset");
      check("reset_small_rx_ready", s_rx_ready, 1);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // Pin the model with hand-computed results
      check("model_bad_outcome", model(bad, 8, 0), OUT_ERR);
      check("model_oversize_outcome", model('{8'hA5, 8'h10}, 4, 0), OUT_ERR);
      check("model_prefix_outcome", model(prefix, 8, 0), OUT_RUN);

      // Basic load
      outcome = model(basic, 8, 1);
      check("model_basic_outcome", outcome, OUT_DONE);
      check("model_basic_w0", exp_wr[0], 16'h0011);
      check("model_basic_w1", exp_wr[1], 16'h0122);
      check("model_basic_w2", exp_wr[2], 16'h0233);
      wr_cyc.delete();
      n0 = n_writes;
      send_stream(basic, 0);
      expect_done("basic", 3);
      if (wr_cyc.size() == 3) begin
         check("basic_consecutive_01", wr_cyc[1] - wr_cyc[0], 1);
         check("basic_consecutive_12", wr_cyc[2] - wr_cyc[1], 1);
      end else begin
         check("basic_write_stamps", wr_cyc.size(), 3);
      end
      pulse_restart();

      // Bad checksum
      outcome = model(bad, 8, 1);
      n0 = n_writes;
      send_stream(bad, 0);
      check("bad_error", error, 1);
      check("bad_done", done, 0);
      check("bad_core_run", core_run, 0);
      check("bad_rx_ready", rx_ready, 0);
      check("bad_write_count", n_writes - n0, 3);
      check("bad_pending_writes", exp_wr.size(), 0);
      pulse_restart();

      // Junk before the marker
      outcome = model(junk, 8, 1);
      check("model_junk_outcome", outcome, OUT_DONE);
      check("model_junk_writes", exp_wr.size(), 3);
      n0 = n_writes;
      send_stream(junk, 0);
      expect_done("junk", 3);
      pulse_restart();

      // Backpressure gaps
      outcome = model(basic, 8, 1);
      n0 = n_writes;
      send_stream(basic, 3);
      expect_done("gaps", 3);
      pulse_restart();

      // Restart after two data bytes, then a full frame from address 0
      outcome = model(prefix, 8, 1);
      send_stream(prefix, 0);
      pulse_restart();
      check("abort_pending_writes", exp_wr.size(), 0);
      outcome = model(basic, 8, 1);
      n0 = n_writes;
      send_stream(basic, 0);
      expect_done("after_abort", 3);

      // Reset while running drops core_run immediately
      #2 n_rst = 1'b0;
      #1 check_reset_values("reset_after_done");
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // Reset mid-DATA
      outcome = model(prefix, 8, 1);
      send_stream(prefix, 0);
      #2 n_rst = 1'b0;
      #1 check_reset_values("reset_mid_data");
      check("reset_mid_pending_writes", exp_wr.size(), 0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      outcome = model(basic, 8, 1);
      n0 = n_writes;
      send_stream(basic, 0);
      expect_done("after_reset", 3);
      pulse_restart();

      // Oversize frame on a 16-deep memory, then the largest legal length
      s_send(8'hA5);
      s_send(8'h10);
      check("oversize_error", s_error, 1);
      check("oversize_done", s_done, 0);
      check("oversize_core_run", s_core_run, 0);
      check("oversize_rx_ready", s_rx_ready, 0);
      check("oversize_writes", s_writes, 0);
      s_restart = 1'b1;
      @(negedge clk);
      s_restart = 1'b0;
      check("small_restart_error", s_error, 0);
      check("small_restart_rx_ready", s_rx_ready, 1);
      s_send(8'hA5);
      s_send(8'h0F);
      check("maxlen_error", s_error, 0);
      check("maxlen_rx_ready", s_rx_ready, 1);
      s_send(8'h5C);
      @(negedge clk);
      check("maxlen_first_write", s_writes, 1);
      s_restart = 1'b1;
      @(negedge clk);
      s_restart = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
